bcd_score_accum: RTL and testbench
==================================

# bcd_score_accum

Parameterised BCD score accumulator for the Tetris datapath. It sits between the line-clear detector and the seven-segment/VGA score display. Each accepted line-clear event adds a level-weighted point value to a DIGITS-wide packed-BCD score. The block also tracks lines, game level, a sticky overflow flag and a high score that survives new games.

## Interface
Parameters:
- DIGITS, 4: number of BCD digits in score and high score; legal range 2..8.
- SATURATE, 1: 1 = clamp score at all-9s on overflow; 0 = wrap modulo 10^DIGITS.
- LINES_PER_LEVEL, 10: cleared lines per level increment; legal range 1..15.
- MAX_LEVEL, 9: level ceiling; legal range 0..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  reset, synchronous, active-low; clock clk.
- clear  in  1  new-game pulse; synchronous, active-high.
- add_valid  in  1  line-clear event request.
- add_lines  in  3  lines cleared by this event, 1..4.
- add_ready  out  1  high only in IDLE; event accepted on edge where add_valid && add_ready.
- busy  out  1  equals !add_ready.
- score_bcd  out  4*DIGITS  current score, packed BCD, digit 0 in [3:0].
- high_bcd  out  4*DIGITS  high score, packed BCD.
- level  out  4  current level, binary, 0..MAX_LEVEL.
- overflow  out  1  sticky; set when any add carries out of the top digit.

## Operation
- Base points (BCD): add_lines 1→10, 2→30, 3→50, 4→80. add_lines 0 or 5..7 with add_valid in IDLE: no-op; no state change, add_ready stays high.
- Points per event: base × (level+1), applied as level+1 successive BCD additions of base. Level is sampled at acceptance.
- FSM states:
  - IDLE: add_ready=1. Valid accept loads rep_cnt=level and base, then goes to ADD.
  - ADD: each cycle, score ← score + base. When rep_cnt==0, go to CMP; otherwise decrement rep_cnt.
  - CMP: one cycle. Update line/level counters and the high score, then return to IDLE.
- BCD adder: combinational ripple across DIGITS digits. A digit sum >9 is adjusted by +6 and carries 1. Carry out of the top digit is overflow.
- Overflow behaviour:
  - Overflow sets the sticky overflow flag.
  - SATURATE=1: score is forced to all 9s and stays there for later adds until clear/reset.
  - SATURATE=0: score keeps the wrapped sum.
- Level tracking: line_in_level counter accumulates add_lines in CMP. On reaching ≥LINES_PER_LEVEL, it subtracts LINES_PER_LEVEL and level increments, saturating at MAX_LEVEL. At most one level step per event.
- High score: in CMP, if score > high_bcd (unsigned BCD compare), high_bcd ← score. high_bcd is cleared only by resetn, never by clear.
- clear:
  - Zeroes score, level, line_in_level and overflow, and forces IDLE.
  - Aborts any in-progress ADD/CMP; a partial add is discarded and the high score is not updated.
  - clear wins over a simultaneous accept; the event is dropped.
- resetn low: everything zeroed, state IDLE. Has priority over clear and add.

## Timing
- Reset values: score_bcd=0, high_bcd=0, level=0, overflow=0, add_ready=1, busy=0.
- Accept on edge E0. ADD occupies edges E1..E(L+1), where L is the level at E0. After edge E(L+1), score_bcd holds the final value.
- CMP is evaluated at edge E(L+2): high_bcd and level update, and add_ready returns high.
- Per-event latency is L+2 cycles. Throughput is one event per L+3 cycles when add_valid is held.
- add_valid during busy is ignored, not queued. The source must hold add_valid until it observes add_ready.
- overflow asserts at the same edge as the overflowing ADD cycle.

## Test plan
- Reset: resetn low 2 cycles → all outputs zero, add_ready=1. Then add_lines=0 with valid → no change, ready stays 1.
- Single event at level 0: add_lines=1 → score_bcd=0x0010 two edges after accept; high_bcd=0x0010 one edge later; busy high for exactly 2 cycles.
- Level weighting: 10 events of add_lines=1 → level=1, score=0x0100. Then add_lines=4 → score=0x0260 (80×2), level unchanged.
- Overflow, DIGITS=4, from score 0x9990 at level 0, add_lines=4:
  - SATURATE=1 → score 0x9999, overflow=1.
  - SATURATE=0 → score 0x0070, overflow=1; high_bcd stays 0x9990.
- clear during ADD at level 3 → next edge score=0, level=0, overflow=0, add_ready=1; high_bcd unchanged.
- clear and accept on the same edge → event dropped, score 0. resetn after a game with high 0x0260 → high_bcd=0.

Source files
------------

// File: rtl/bcd_score_accum.sv
// Packed-BCD score accumulator: level-weighted line-clear points, level tracking,
// sticky overflow and a high score that survives new games.
module bcd_score_accum #(
    parameter int DIGITS          = 4,
    parameter int SATURATE        = 1,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 9
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  add_valid,
    input  logic [2:0]            add_lines,
    output logic                  add_ready,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic [3:0]            level,
    output logic                  overflow
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_CMP} state_t;

    state_t         r_state;
    logic [W-1:0]   r_score;
    logic [W-1:0]   r_high;
    logic [3:0]     r_level;
    logic [3:0]     r_rep;
    logic [7:0]     r_base;
    logic [2:0]     r_lines_evt;
    logic [4:0]     r_line_cnt;
    logic           r_ovf;

    logic [W:0]     w_sum;
    logic [W-1:0]   w_addend;
    logic [7:0]     w_base_sel;
    logic           w_lines_ok;
    logic [5:0]     w_line_sum;

    // Ripple BCD add; result MSB is the carry out of the top digit.
    function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        logic         c;
        logic [4:0]   d;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            if (d > 5'd9) begin
                d = d + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s[4*i +: 4] = d[3:0];
        end
        return {c, s};
    endfunction

    function automatic logic [7:0] base_points(input logic [2:0] n);
        case (n)
            3'd1:    return 8'h10;
            3'd2:    return 8'h30;
            3'd3:    return 8'h50;
            3'd4:    return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

    assign w_base_sel = base_points(add_lines);
    assign w_lines_ok = (add_lines >= 3'd1) && (add_lines <= 3'd4);
    assign w_addend   = W'(r_base);
    assign w_sum      = bcd_add(r_score, w_addend);
    assign w_line_sum = {1'b0, r_line_cnt} + 6'(r_lines_evt);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_score     <= '0;
            r_high      <= '0;
            r_level     <= '0;
            r_rep       <= '0;
            r_base      <= '0;
            r_lines_evt <= '0;
            r_line_cnt  <= '0;
            r_ovf       <= 1'b0;
        end else if (clear) begin
            // New game: the high score is deliberately kept.
            r_state    <= S_IDLE;
            r_score    <= '0;
            r_level    <= '0;
            r_line_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (add_valid && w_lines_ok) begin
                        r_rep       <= r_level;
                        r_base      <= w_base_sel;
                        r_lines_evt <= add_lines;
                        r_state     <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (w_sum[W]) begin
                        r_ovf   <= 1'b1;
                        r_score <= (SATURATE != 0) ? ALL_NINES : w_sum[W-1:0];
                    end else begin
                        r_score <= w_sum[W-1:0];
                    end
                    if (r_rep == 4'd0) begin
                        r_state <= S_CMP;
                    end else begin
                        r_rep <= r_rep - 4'd1;
                    end
                end
                S_CMP: begin
                    if (w_line_sum >= 6'(LINES_PER_LEVEL)) begin
                        r_line_cnt <= 5'(w_line_sum - 6'(LINES_PER_LEVEL));
                        if (r_level != 4'(MAX_LEVEL)) begin
                            r_level <= r_level + 4'd1;
                        end
                    end else begin
                        r_line_cnt <= w_line_sum[4:0];
                    end
                    // Packed BCD orders the same as plain unsigned binary.
                    if (r_score > r_high) begin
                        r_high <= r_score;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign add_ready = (r_state == S_IDLE);
    assign busy      = !add_ready;
    assign score_bcd = r_score;
    assign high_bcd  = r_high;
    assign level     = r_level;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_bcd_score_accum.sv
// Bench for bcd_score_accum: scenario tasks plus randomized play against a decimal game model.
module tb_bcd_score_accum;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, clear, add_valid;
    logic [2:0]  add_lines;
    logic        add_ready, busy, overflow;
    logic [15:0] score_bcd, high_bcd;
    logic [3:0]  level;

    logic        ov_valid;
    logic [2:0]  ov_lines;
    logic        s_ready, s_busy, s_ovf, w_ready, w_busy, w_ovf;
    logic [15:0] s_score, s_high, w_score, w_high;
    logic [3:0]  s_level, w_level;

    bcd_score_accum #(.DIGITS(4), .SATURATE(1), .LINES_PER_LEVEL(10), .MAX_LEVEL(9)) dut (
        .clk(clk), .resetn(resetn), .clear(clear), .add_valid(add_valid), .add_lines(add_lines),
        .add_ready(add_ready), .busy(busy), .score_bcd(score_bcd), .high_bcd(high_bcd),
        .level(level), .overflow(overflow));

    bcd_score_accum #(.DIGITS(4), .SATURATE(1), .LINES_PER_LEVEL(15), .MAX_LEVEL(0)) u_sat (
        .clk(clk), .resetn(resetn), .clear(clear), .add_valid(ov_valid), .add_lines(ov_lines),
        .add_ready(s_ready), .busy(s_busy), .score_bcd(s_score), .high_bcd(s_high),
        .level(s_level), .overflow(s_ovf));

    bcd_score_accum #(.DIGITS(4), .SATURATE(0), .LINES_PER_LEVEL(15), .MAX_LEVEL(0)) u_wrap (
        .clk(clk), .resetn(resetn), .clear(clear), .add_valid(ov_valid), .add_lines(ov_lines),
        .add_ready(w_ready), .busy(w_busy), .score_bcd(w_score), .high_bcd(w_high),
        .level(w_level), .overflow(w_ovf));

    int total = 0;
    int bad   = 0;

    // Decimal game model for the main instance (saturating, 10 lines/level, max level 9).
    int m_score, m_high, m_level, m_lines;
    bit m_ovf;

    function automatic int base_of(input int l);
        case (l)
            1: return 10;
            2: return 30;
            3: return 50;
            4: return 80;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic m_event(input int l);
        int s;
        if (base_of(l) == 0) return;
        s = m_score + base_of(l) * (m_level + 1);
        if (s >= 10000) begin
            m_ovf = 1'b1;
            s = 9999;
        end
        m_score = s;
        m_lines += l;
        if (m_lines >= 10) begin
            m_lines -= 10;
            if (m_level < 9) m_level++;
        end
        if (m_score > m_high) m_high = m_score;
    endtask

    task automatic m_clear();
        m_score = 0; m_level = 0; m_lines = 0; m_ovf = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    // Offer one event while idle; return the number of busy cycles observed (bounded).
    task automatic send(input logic [2:0] l, output int bc);
        @(negedge clk); add_valid = 1'b1; add_lines = l;
        @(negedge clk); add_valid = 1'b0; add_lines = 3'd0;
        bc = 0;
        while (busy === 1'b1 && bc < 40) begin
            bc++;
            @(negedge clk);
        end
    endtask

    task automatic ov_send(input logic [2:0] l);
        int n;
        @(negedge clk); ov_valid = 1'b1; ov_lines = l;
        @(negedge clk); ov_valid = 1'b0; ov_lines = 3'd0;
        n = 0;
        while ((s_busy === 1'b1 || w_busy === 1'b1) && n < 40) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != 2) begin bad++; $display("FAIL ov_latency: got %0d want 2", n); end
    endtask

    task automatic test_reset();
        resetn = 1'b0; clear = 1'b0; add_valid = 1'b0; add_lines = 3'd0;
        ov_valid = 1'b0; ov_lines = 3'd0;
        m_clear(); m_high = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        total++;
        if ({score_bcd, high_bcd, level, overflow} !== 37'd0) begin
            bad++; $display("FAIL reset_outputs: got %h %h %h %b want zeros", score_bcd, high_bcd, level, overflow);
        end
        total++;
        if ({add_ready, busy} !== 2'b10 || {s_ready, w_ready} !== 2'b11) begin
            bad++; $display("FAIL reset_ready: got %b%b want 10", add_ready, busy);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); add_valid = 1'b1; add_lines = (k == 0) ? 3'd0 : 3'd5;
            @(negedge clk); add_valid = 1'b0;
            total++;
            if (add_ready !== 1'b1 || score_bcd !== 16'h0) begin
                bad++; $display("FAIL noop_lines: got ready=%b score=%h want 1 0000", add_ready, score_bcd);
            end
        end
    endtask

    task automatic test_single();
        @(negedge clk); add_valid = 1'b1; add_lines = 3'd1;
        @(negedge clk); add_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL single_busy1: got %b want 1", busy); end
        @(negedge clk);
        total++;
        if (score_bcd !== 16'h0010 || high_bcd !== 16'h0 || busy !== 1'b1) begin
            bad++; $display("FAIL single_add: got score=%h high=%h busy=%b want 0010 0000 1", score_bcd, high_bcd, busy);
        end
        @(negedge clk);
        total++;
        if (high_bcd !== 16'h0010 || add_ready !== 1'b1) begin
            bad++; $display("FAIL single_cmp: got high=%h ready=%b want 0010 1", high_bcd, add_ready);
        end
        m_event(1);
    endtask

    task automatic test_level();
        int bc;
        pulse_clear(); m_clear();
        total++;
        if (score_bcd !== 16'h0 || high_bcd !== 16'h0010) begin
            bad++; $display("FAIL clear_keeps_high: got score=%h high=%h want 0000 0010", score_bcd, high_bcd);
        end
        for (int k = 0; k < 10; k++) begin
            send(3'd1, bc); m_event(1);
        end
        total++;
        if (score_bcd !== 16'h0100 || level !== 4'd1) begin
            bad++; $display("FAIL level_up: got score=%h level=%0d want 0100 1", score_bcd, level);
        end
        send(3'd4, bc); m_event(4);
        total++;
        if (score_bcd !== 16'h0260 || level !== 4'd1 || high_bcd !== 16'h0260 || bc != 3) begin
            bad++; $display("FAIL level_weight: got score=%h level=%0d high=%h lat=%0d want 0260 1 0260 3", score_bcd, level, high_bcd, bc);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        pulse_clear(); m_clear();
        @(negedge clk); add_valid = 1'b1; add_lines = 3'd1;
        repeat (10) @(negedge clk);
        add_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
        for (int k = 0; k < 4; k++) m_event(1);
        total++;
        if (score_bcd !== 16'h0040 || score_bcd !== to_bcd(m_score)) begin
            bad++; $display("FAIL back_to_back: got score=%h want 0040", score_bcd);
        end
    endtask

    task automatic test_clear_add();
        int bc, hi, guard;
        pulse_clear(); m_clear();
        guard = 0;
        while (m_level < 3 && guard < 20) begin
            send(3'd4, bc); m_event(4); guard++;
        end
        total++;
        if (level !== 4'd3 || score_bcd !== to_bcd(m_score)) begin
            bad++; $display("FAIL prep_level3: got level=%0d score=%h want 3 %h", level, score_bcd, to_bcd(m_score));
        end
        hi = m_high;
        @(negedge clk); add_valid = 1'b1; add_lines = 3'd2;
        @(negedge clk); add_valid = 1'b0;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        m_clear();
        total++;
        if (score_bcd !== 16'h0 || level !== 4'd0 || overflow !== 1'b0 || add_ready !== 1'b1 || high_bcd !== to_bcd(hi)) begin
            bad++; $display("FAIL clear_mid_add: got score=%h level=%0d ovf=%b ready=%b high=%h want 0000 0 0 1 %h",
                            score_bcd, level, overflow, add_ready, high_bcd, to_bcd(hi));
        end
        repeat (4) @(negedge clk);
        total++;
        if (score_bcd !== 16'h0 || high_bcd !== to_bcd(hi) || busy !== 1'b0) begin
            bad++; $display("FAIL clear_aborts: got score=%h high=%h busy=%b", score_bcd, high_bcd, busy);
        end
    endtask

    task automatic test_clear_accept();
        @(negedge clk); clear = 1'b1; add_valid = 1'b1; add_lines = 3'd4;
        @(negedge clk); clear = 1'b0; add_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (score_bcd !== 16'h0 || add_ready !== 1'b1) begin
            bad++; $display("FAIL clear_vs_accept: got score=%h ready=%b want 0000 1", score_bcd, add_ready);
        end
    endtask

    task automatic test_random();
        int bc, l, l0, exp_bc;
        pulse_clear(); m_clear();
        for (int k = 0; k < 70; k++) begin
            l = $urandom_range(0, 7);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            l0 = m_level;
            exp_bc = (base_of(l) != 0) ? l0 + 2 : 0;
            send(3'(l), bc);
            m_event(l);
            total++;
            if (bc != exp_bc) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", k, bc, exp_bc); end
            total++;
            if (score_bcd !== to_bcd(m_score) || high_bcd !== to_bcd(m_high) || level !== 4'(m_level) || overflow !== m_ovf) begin
                bad++; $display("FAIL rnd_state[%0d]: got score=%h high=%h level=%0d ovf=%b want %h %h %0d %b",
                                k, score_bcd, high_bcd, level, overflow, to_bcd(m_score), to_bcd(m_high), m_level, m_ovf);
            end
        end
    endtask

    task automatic test_overflow();
        pulse_clear();
        for (int k = 0; k < 124; k++) ov_send(3'd4);
        ov_send(3'd3); ov_send(3'd1); ov_send(3'd1);
        total++;
        if (s_score !== 16'h9990 || w_score !== 16'h9990 || s_ovf !== 1'b0 || w_ovf !== 1'b0) begin
            bad++; $display("FAIL ov_prep: got %h %h %b %b want 9990 9990 0 0", s_score, w_score, s_ovf, w_ovf);
        end
        @(negedge clk); ov_valid = 1'b1; ov_lines = 3'd4;
        @(negedge clk); ov_valid = 1'b0;
        @(negedge clk);
        total++;
        if (s_ovf !== 1'b1 || s_score !== 16'h9999) begin
            bad++; $display("FAIL ov_sat: got score=%h ovf=%b want 9999 1", s_score, s_ovf);
        end
        total++;
        if (w_ovf !== 1'b1 || w_score !== 16'h0070) begin
            bad++; $display("FAIL ov_wrap: got score=%h ovf=%b want 0070 1", w_score, w_ovf);
        end
        @(negedge clk);
        total++;
        if (s_high !== 16'h9999 || w_high !== 16'h9990 || s_ready !== 1'b1 || w_ready !== 1'b1) begin
            bad++; $display("FAIL ov_high: got sat=%h wrap=%h want 9999 9990", s_high, w_high);
        end
        ov_send(3'd1);
        total++;
        if (s_score !== 16'h9999 || w_score !== 16'h0080 || w_ovf !== 1'b1) begin
            bad++; $display("FAIL ov_sticky: got sat=%h wrap=%h ovf=%b want 9999 0080 1", s_score, w_score, w_ovf);
        end
    endtask

    task automatic test_reset_high();
        @(negedge clk); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
        m_clear(); m_high = 0;
        total++;
        if (high_bcd !== 16'h0 || score_bcd !== 16'h0 || level !== 4'd0 || s_high !== 16'h0 || s_ovf !== 1'b0) begin
            bad++; $display("FAIL reset_high: got high=%h score=%h level=%0d sat_high=%h", high_bcd, score_bcd, level, s_high);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_level();
        test_back_to_back();
        test_clear_add();
        test_clear_accept();
        test_random();
        test_overflow();
        test_reset_high();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
